// File: rtl/camera_capture_if.sv
// Camera byte stream in, pixel-FIFO write port out.
// The capture block is the master; the camera/FIFO side is the slave.
interface camera_capture_if;
  logic [7:0]  camera_data;
  logic        href;
  logic        vsync;
  logic        fifo_full;
  logic        fifo_wrreq;
  logic [31:0] fifo_data;

  modport master (input camera_data, href, vsync, fifo_full, output fifo_wrreq, fifo_data);
  modport slave  (output camera_data, href, vsync, fifo_full, input fifo_wrreq, fifo_data);
endinterface

// File: rtl/camera_capture.sv
// YUYV camera capture: byte deserialiser, 2-lane YUV->RGB, framed FIFO writes.
// One 4-byte group yields two pixels, written 2 and 3 cycles after the V byte.
module camera_capture #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic             pixel_clock,
  input  logic             reset,
  camera_capture_if.master cam,
  output logic             frame_done,
  output logic             overflow,
  output logic [7:0]       frame_count
);
  localparam logic [1:0] WAIT_VS = 2'd0;
  localparam logic [1:0] ACTIVE  = 2'd1;
  localparam logic [1:0] DROP    = 2'd2;

  localparam int STAGES = 2;
  localparam int CW = $clog2(WIDTH + 3);
  localparam int LW = $clog2(HEIGHT + 2);
  localparam logic [CW-1:0] COL_MAX  = CW'(WIDTH);
  localparam logic [LW-1:0] LINE_MAX = LW'(HEIGHT);
  localparam logic [18:0]   LAST_PIX = 19'(WIDTH * HEIGHT - 1);

  typedef struct packed {
    logic signed [10:0] r;
    logic signed [10:0] g;
    logic signed [10:0] b;
  } sum_t;

  logic [1:0]        state, phase;
  logic              vsync_q, href_q, sop_pending;
  logic [7:0]        y0_r, u_r, y1_r;
  logic [1:0][7:0]   s1_y;
  logic [7:0]        s1_u, s1_v;
  logic [1:0]        s1_keep, s2_keep;
  logic [STAGES:0]   vld_pipe;
  sum_t [1:0]        sum_c, sum_q;
  logic [CW-1:0]     col;
  logic [LW-1:0]     line;
  logic [18:0]       pix_cnt;

  logic signed [10:0] up, vp;
  assign up = $signed({3'b000, s1_u}) - 11'sd128;
  assign vp = $signed({3'b000, s1_v}) - 11'sd128;

  // Both pixels of a group share U/V; each lane has its own luma.
  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic signed [10:0] yp;
    assign yp         = $signed({3'b000, s1_y[l]}) - 11'sd16;
    assign sum_c[l].r = yp + vp + (vp >>> 2);
    assign sum_c[l].g = yp - (up >>> 2) - (vp >>> 1);
    assign sum_c[l].b = yp + up + (up >>> 1);
  end

  function automatic logic [7:0] clamp8(input logic signed [10:0] v);
    if (v[10])            return 8'd0;
    else if (v > 11'sd255) return 8'hFF;
    else                  return v[7:0];
  endfunction

  logic       p0_ok, p1_ok, wr_due, eop;
  sum_t       pix_sel;
  assign p0_ok   = (col < COL_MAX) && (line < LINE_MAX);
  assign p1_ok   = ((col + CW'(1)) < COL_MAX) && (line < LINE_MAX);
  assign pix_sel = vld_pipe[1] ? sum_q[0] : sum_q[1];
  assign wr_due  = (state == ACTIVE) &&
                   ((vld_pipe[1] && s2_keep[0]) || (vld_pipe[2] && s2_keep[1]));
  assign eop     = (pix_cnt == LAST_PIX);

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state          <= WAIT_VS;
      phase          <= 2'd0;
      vsync_q        <= 1'b0;
      href_q         <= 1'b0;
      sop_pending    <= 1'b0;
      y0_r           <= '0;
      u_r            <= '0;
      y1_r           <= '0;
      s1_y           <= '0;
      s1_u           <= '0;
      s1_v           <= '0;
      s1_keep        <= '0;
      s2_keep        <= '0;
      vld_pipe       <= '0;
      sum_q          <= '0;
      col            <= '0;
      line           <= '0;
      pix_cnt        <= '0;
      cam.fifo_wrreq <= 1'b0;
      cam.fifo_data  <= '0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
      frame_count    <= '0;
    end else begin
      cam.fifo_wrreq <= 1'b0;
      frame_done     <= 1'b0;
      vsync_q        <= cam.vsync;
      href_q         <= cam.href;
      vld_pipe       <= {vld_pipe[STAGES-1:0], 1'b0};
      if (vld_pipe[0]) begin
        sum_q   <= sum_c;
        s2_keep <= s1_keep;
      end

      if (cam.vsync) begin
        // Frame (re)start, also aborts anything still in the pipeline.
        state       <= WAIT_VS;
        phase       <= 2'd0;
        col         <= '0;
        line        <= '0;
        pix_cnt     <= '0;
        overflow    <= 1'b0;
        sop_pending <= 1'b1;
        vld_pipe    <= '0;
      end else begin
        case (state)
          ACTIVE: begin
            if (!cam.href) begin
              phase <= 2'd0;
              if (href_q && col != '0) begin
                col <= '0;
                if (line < LINE_MAX) line <= line + LW'(1);
              end
            end else begin
              phase <= phase + 2'd1;
              case (phase)
                2'd0:    y0_r <= cam.camera_data;
                2'd1:    u_r  <= cam.camera_data;
                2'd2:    y1_r <= cam.camera_data;
                default: begin
                  s1_y        <= {y1_r, y0_r};
                  s1_u        <= u_r;
                  s1_v        <= cam.camera_data;
                  s1_keep     <= {p1_ok, p0_ok};
                  vld_pipe[0] <= 1'b1;
                  if (col < COL_MAX) col <= col + CW'(2);
                end
              endcase
            end

            if (wr_due) begin
              if (cam.fifo_full) begin
                overflow <= 1'b1;
                state    <= DROP;
                vld_pipe <= '0;
              end else begin
                cam.fifo_wrreq <= 1'b1;
                cam.fifo_data  <= {6'b0, eop, sop_pending,
                                   clamp8(pix_sel.r), clamp8(pix_sel.g), clamp8(pix_sel.b)};
                sop_pending    <= 1'b0;
                pix_cnt        <= pix_cnt + 19'd1;
                if (eop) begin
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + 8'd1;
                  state       <= WAIT_VS;
                  vld_pipe    <= '0;
                end
              end
            end
          end
          WAIT_VS: begin
            phase    <= 2'd0;
            vld_pipe <= '0;
            if (vsync_q) state <= ACTIVE;
          end
          default: begin
            phase    <= 2'd0;
            vld_pipe <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture with a 4x2 frame.
module tb_camera_capture;
  logic       clk = 1'b0;
  logic       rst;
  logic       frame_done, overflow;
  logic [7:0] frame_count;

  always #5 clk = ~clk;

  camera_capture_if bus();

  camera_capture #(.WIDTH(4), .HEIGHT(2)) dut (
    .pixel_clock (clk),
    .reset       (rst),
    .cam         (bus),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .frame_count (frame_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wq[$];
  int          wc[$];
  int          fd_cyc[$];
  always @(negedge clk) begin
    if (bus.fifo_wrreq) begin
      wq.push_back(bus.fifo_data);
      wc.push_back(cyc);
    end
    if (frame_done) fd_cyc.push_back(cyc);
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] wget(input int i);
    return (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
  endfunction
  function automatic int cget(input int i);
    return (i < wc.size()) ? wc[i] : -1;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic send_byte(input logic [7:0] b);
    bus.href = 1'b1; bus.camera_data = b; tick();
  endtask
  task automatic send_group(input logic [7:0] y0, u, y1, v, output int vc);
    send_byte(y0); send_byte(u); send_byte(y1); send_byte(v);
    vc = cyc;
  endtask
  task automatic line_end(input int n);
    bus.href = 1'b0; tick(n);
  endtask
  task automatic start_frame;
    bus.href = 1'b0; bus.vsync = 1'b1; tick(2);
    bus.vsync = 1'b0; tick(1);
  endtask
  task automatic clear_mon;
    wq.delete(); wc.delete(); fd_cyc.delete();
  endtask

  task automatic test_reset;
    int vc;
    rst = 1'b1; bus.vsync = 1'b0; bus.href = 1'b0; bus.camera_data = 8'h00; bus.fifo_full = 1'b0;
    tick(3);
    clear_mon();
    n_cmp++; if (bus.fifo_wrreq !== 1'b0) begin n_bad++; $display("FAIL reset_wrreq: got %b want 0", bus.fifo_wrreq); end
    n_cmp++; if (bus.fifo_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", bus.fifo_data); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (frame_count !== 8'd0) begin n_bad++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    rst = 1'b0;
    send_group(8'h80, 8'h80, 8'h80, 8'h80, vc);
    line_end(4);
    n_cmp++; if (wq.size() != 0) begin n_bad++; $display("FAIL wait_vs_no_write: got %0d writes want 0", wq.size()); end
  endtask

  task automatic test_gray;
    int vc;
    clear_mon(); start_frame();
    send_group(8'h80, 8'h80, 8'h80, 8'h80, vc);
    line_end(4);
    n_cmp++; if (wq.size() != 2) begin n_bad++; $display("FAIL gray_count: got %0d want 2", wq.size()); end
    n_cmp++; if (wget(0) !== 32'h01707070) begin n_bad++; $display("FAIL gray_px0: got %h want 01707070", wget(0)); end
    n_cmp++; if (cget(0) != vc + 2) begin n_bad++; $display("FAIL gray_px0_lat: got %0d want %0d", cget(0), vc + 2); end
    n_cmp++; if (wget(1) !== 32'h00707070) begin n_bad++; $display("FAIL gray_px1: got %h want 00707070", wget(1)); end
    n_cmp++; if (cget(1) != vc + 3) begin n_bad++; $display("FAIL gray_px1_lat: got %0d want %0d", cget(1), vc + 3); end
    n_cmp++; if (bus.fifo_data !== 32'h00707070) begin n_bad++; $display("FAIL gray_hold: got %h want 00707070", bus.fifo_data); end
  endtask

  task automatic test_clamp;
    int vc, vc2;
    clear_mon(); start_frame();
    send_group(8'hEB, 8'h80, 8'h10, 8'hFF, vc);
    send_group(8'h80, 8'h00, 8'h80, 8'h80, vc2);
    line_end(4);
    n_cmp++; if (wq.size() != 4) begin n_bad++; $display("FAIL clamp_count: got %0d want 4", wq.size()); end
    n_cmp++; if (wget(0) !== 32'h01FF9CDB) begin n_bad++; $display("FAIL clamp_px0: got %h want 01FF9CDB", wget(0)); end
    n_cmp++; if (wget(1) !== 32'h009E0000) begin n_bad++; $display("FAIL clamp_px1: got %h want 009E0000", wget(1)); end
    n_cmp++; if (wget(2) !== 32'h00709000) begin n_bad++; $display("FAIL negu_px0: got %h want 00709000", wget(2)); end
    n_cmp++; if (wget(3) !== 32'h00709000) begin n_bad++; $display("FAIL negu_px1: got %h want 00709000", wget(3)); end
    n_cmp++; if (cget(2) != vc2 + 2) begin n_bad++; $display("FAIL b2b_lat: got %0d want %0d", cget(2), vc2 + 2); end
  endtask

  task automatic test_full_frame;
    int vc;
    logic [7:0]  v;
    logic [31:0] exp;
    clear_mon(); start_frame();
    n_cmp++; if (frame_count !== 8'd0) begin n_bad++; $display("FAIL ff_count_pre: got %0d want 0", frame_count); end
    send_group(8'h20, 8'h80, 8'h30, 8'h80, vc);
    send_group(8'h40, 8'h80, 8'h50, 8'h80, vc);
    send_group(8'hF0, 8'h80, 8'hF0, 8'h80, vc);   // beyond WIDTH: dropped
    line_end(2);
    send_group(8'h60, 8'h80, 8'h70, 8'h80, vc);
    send_group(8'h80, 8'h80, 8'h90, 8'h80, vc);
    line_end(5);
    n_cmp++; if (wq.size() != 8) begin n_bad++; $display("FAIL ff_count: got %0d want 8", wq.size()); end
    for (int p = 0; p < 8; p++) begin
      v   = 8'(16 * (p + 1));
      exp = {6'b0, p == 7, p == 0, v, v, v};
      n_cmp++; if (wget(p) !== exp) begin n_bad++; $display("FAIL ff_px%0d: got %h want %h", p, wget(p), exp); end
    end
    n_cmp++; if (fd_cyc.size() != 1) begin n_bad++; $display("FAIL ff_done_pulses: got %0d want 1", fd_cyc.size()); end
    n_cmp++; if (fd_cyc.size() < 1 || fd_cyc[0] != cget(7)) begin n_bad++; $display("FAIL ff_done_cycle: want %0d", cget(7)); end
    n_cmp++; if (frame_count !== 8'd1) begin n_bad++; $display("FAIL ff_count_post: got %0d want 1", frame_count); end
    send_group(8'h80, 8'h80, 8'h80, 8'h80, vc);
    line_end(4);
    n_cmp++; if (wq.size() != 8) begin n_bad++; $display("FAIL ff_after_eop: got %0d want 8", wq.size()); end
  endtask

  task automatic test_overflow;
    int vc;
    clear_mon(); start_frame();
    send_group(8'h80, 8'h80, 8'h80, 8'h80, vc);
    line_end(4);
    bus.fifo_full = 1'b1;
    send_group(8'h80, 8'h80, 8'h80, 8'h80, vc);
    send_byte(8'h80); send_byte(8'h80);            // 3rd pixel due here, FIFO full
    bus.fifo_full = 1'b0;
    send_byte(8'h80); send_byte(8'h80);
    line_end(6);
    n_cmp++; if (wq.size() != 2) begin n_bad++; $display("FAIL ovf_writes: got %0d want 2", wq.size()); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    n_cmp++; if (frame_count !== 8'd1) begin n_bad++; $display("FAIL ovf_frame_count: got %0d want 1", frame_count); end
    n_cmp++; if (fd_cyc.size() != 0) begin n_bad++; $display("FAIL ovf_done: got %0d want 0", fd_cyc.size()); end
    start_frame();
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_partial_line;
    int vc;
    clear_mon(); start_frame();
    send_group(8'h80, 8'h80, 8'h80, 8'h80, vc);
    send_byte(8'h50); send_byte(8'h80);
    line_end(4);
    n_cmp++; if (wq.size() != 2) begin n_bad++; $display("FAIL part_writes: got %0d want 2", wq.size()); end
    send_group(8'h90, 8'h80, 8'hA0, 8'h80, vc);
    send_group(8'hB0, 8'h80, 8'hC0, 8'h80, vc);
    line_end(5);
    n_cmp++; if (wq.size() != 6) begin n_bad++; $display("FAIL part_col_reset: got %0d want 6", wq.size()); end
    n_cmp++; if (wget(2) !== 32'h00808080) begin n_bad++; $display("FAIL part_realign: got %h want 00808080", wget(2)); end
    n_cmp++; if (wget(5) !== 32'h00B0B0B0) begin n_bad++; $display("FAIL part_last: got %h want 00B0B0B0", wget(5)); end
  endtask

  task automatic test_vsync_abort;
    int vc;
    clear_mon(); start_frame();
    send_group(8'h80, 8'h80, 8'h80, 8'h80, vc);
    bus.href = 1'b0; bus.vsync = 1'b1;
    tick(5);
    n_cmp++; if (wq.size() != 0) begin n_bad++; $display("FAIL abort_writes: got %0d want 0", wq.size()); end
    bus.vsync = 1'b0; tick(1);
  endtask

  task automatic test_reset_mid;
    int vc;
    clear_mon(); start_frame();
    send_group(8'h80, 8'h80, 8'h80, 8'h80, vc);
    rst = 1'b1; tick(1);
    n_cmp++; if (bus.fifo_wrreq !== 1'b0) begin n_bad++; $display("FAIL rmid_wrreq: got %b want 0", bus.fifo_wrreq); end
    n_cmp++; if (frame_count !== 8'd0) begin n_bad++; $display("FAIL rmid_frame_count: got %0d want 0", frame_count); end
    rst = 1'b0; tick(4);
    send_group(8'h80, 8'h80, 8'h80, 8'h80, vc);
    line_end(4);
    n_cmp++; if (wq.size() != 0) begin n_bad++; $display("FAIL rmid_no_write: got %0d want 0", wq.size()); end
    start_frame();
    send_group(8'h80, 8'h80, 8'h80, 8'h80, vc);
    line_end(4);
    n_cmp++; if (wq.size() != 2) begin n_bad++; $display("FAIL rmid_resume: got %0d want 2", wq.size()); end
    n_cmp++; if (wget(0) !== 32'h01707070) begin n_bad++; $display("FAIL rmid_sop: got %h want 01707070", wget(0)); end
  endtask

  initial begin
    test_reset();
    test_gray();
    test_clamp();
    test_full_frame();
    test_overflow();
    test_partial_line();
    test_vsync_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
